// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings, shadow-stage record and match helper for the hazard unit
package hazard_ctrl_pkg;
    localparam logic [1:0] REGDST_RT    = 2'b00;
    localparam logic [1:0] REGDST_RD    = 2'b01;
    localparam logic [1:0] REGDST_LINK  = 2'b10;
    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         LINK_REG_DEF = 31;

    typedef struct packed {
        logic       rw;
        logic       mr;
        logic [4:0] rd;
    } shadow_t;

    function automatic logic reg_match(input shadow_t s, input logic [4:0] r);
        return s.rw && s.rd == r && r != REG_ZERO;
    endfunction
endpackage

// File: rtl/hazard_shadow_stage.sv
// hazard_shadow_stage: resettable shadow register for one pipeline stage with bubble insertion
module hazard_shadow_stage
    import hazard_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    i_bubble,
    input  shadow_t i_d,
    output shadow_t o_q
);
    shadow_t r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_q <= '0;
        else       r_q <= i_bubble ? '0 : i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard detection, stall/flush steering and saturating stall counter
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs,
    input  logic [4:0]       Rt,
    input  logic [4:0]       Rd,
    input  logic             UseRt,
    input  logic [1:0]       RegDstID,
    input  logic             RegWriteID,
    input  logic             MemReadID,
    input  logic             BranchID,
    input  logic             BranchTaken,
    input  logic             JumpID,
    input  logic             JRID,
    output logic             StallID,
    output logic             FlushIF,
    output logic [4:0]       ExWriteReg,
    output logic [CNT_W-1:0] StallCount
);
    logic [4:0]       w_wr;
    logic             w_wvalid;
    logic             w_load_use;
    logic             w_br_dep;
    logic             w_jr_dep;
    logic             w_stall;
    shadow_t          w_id;
    shadow_t          w_ex;
    shadow_t          w_mem;
    logic [CNT_W-1:0] r_cnt;

    assign w_wr     = (RegDstID == REGDST_RT)   ? Rt :
                      (RegDstID == REGDST_LINK) ? 5'(LINK_REG) : Rd;
    assign w_wvalid = RegWriteID && w_wr != REG_ZERO;
    // A load to $0 collapses to a bubble here, so it can never trigger a stall.
    assign w_id     = '{rw: w_wvalid, mr: MemReadID && w_wvalid, rd: w_wr};

    hazard_shadow_stage u_ex (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (w_stall),
        .i_d      (w_id),
        .o_q      (w_ex)
    );

    hazard_shadow_stage u_mem (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_d      (w_ex),
        .o_q      (w_mem)
    );

    assign w_load_use = w_ex.mr && (reg_match(w_ex, Rs) || (UseRt && reg_match(w_ex, Rt)));
    assign w_br_dep   = BranchID && (reg_match(w_ex, Rs) || reg_match(w_ex, Rt) ||
                        (w_mem.mr && (reg_match(w_mem, Rs) || reg_match(w_mem, Rt))));
    assign w_jr_dep   = JRID && (reg_match(w_ex, Rs) || (w_mem.mr && reg_match(w_mem, Rs)));
    assign w_stall    = w_load_use || w_br_dep || w_jr_dep;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    r_cnt <= '0;
        else if (w_stall && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign StallID    = w_stall;
    assign FlushIF    = !w_stall && (JumpID || (BranchID && BranchTaken));
    assign ExWriteReg = w_ex.rd;
    assign StallCount = r_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl stall, flush, reset and counter behaviour
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  Rs, Rt, Rd;
    logic        UseRt, RegWriteID, MemReadID, BranchID, BranchTaken, JumpID, JRID;
    logic [1:0]  RegDstID;
    logic        StallID, FlushIF, StallID4, FlushIF4;
    logic [4:0]  ExWriteReg, ExWriteReg4;
    logic [15:0] StallCount;
    logic [3:0]  StallCount4;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .Rs(Rs), .Rt(Rt), .Rd(Rd), .UseRt(UseRt),
        .RegDstID(RegDstID), .RegWriteID(RegWriteID), .MemReadID(MemReadID),
        .BranchID(BranchID), .BranchTaken(BranchTaken), .JumpID(JumpID), .JRID(JRID),
        .StallID(StallID), .FlushIF(FlushIF), .ExWriteReg(ExWriteReg), .StallCount(StallCount)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .Rs(Rs), .Rt(Rt), .Rd(Rd), .UseRt(UseRt),
        .RegDstID(RegDstID), .RegWriteID(RegWriteID), .MemReadID(MemReadID),
        .BranchID(BranchID), .BranchTaken(BranchTaken), .JumpID(JumpID), .JRID(JRID),
        .StallID(StallID4), .FlushIF(FlushIF4), .ExWriteReg(ExWriteReg4), .StallCount(StallCount4)
    );

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic urt, input logic [1:0] dst, input logic rw, input logic mr,
                       input logic br, input logic tk, input logic jmp, input logic jr);
        Rs = rs; Rt = rt; Rd = rd; UseRt = urt; RegDstID = dst; RegWriteID = rw;
        MemReadID = mr; BranchID = br; BranchTaken = tk; JumpID = jmp; JRID = jr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops();
        drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (StallID !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%b exp=0", StallID); end
        n_cmp++; if (FlushIF !== 1'b0) begin n_err++; $display("FAIL rst_flush got=%b exp=0", FlushIF); end
        n_cmp++; if (ExWriteReg !== 5'd0) begin n_err++; $display("FAIL rst_exwr got=%0d exp=0", ExWriteReg); end
        n_cmp++; if (StallCount !== 16'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", StallCount); end
    endtask

    task automatic test_load_use();
        drv(29, 8, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0);
        n_cmp++; if (StallID !== 1'b0) begin n_err++; $display("FAIL lu_lw_stall got=%b exp=0", StallID); end
        tick();
        n_cmp++; if (ExWriteReg !== 5'd8) begin n_err++; $display("FAIL lu_exwr got=%0d exp=8", ExWriteReg); end
        drv(8, 10, 9, 1, 2'b01, 1, 0, 0, 0, 0, 0);
        n_cmp++; if (StallID !== 1'b1) begin n_err++; $display("FAIL lu_stall got=%b exp=1", StallID); end
        tick();
        exp_cnt++;
        n_cmp++; if (StallID !== 1'b0) begin n_err++; $display("FAIL lu_release got=%b exp=0", StallID); end
        n_cmp++; if (StallCount !== 16'(exp_cnt)) begin n_err++; $display("FAIL lu_cnt got=%0d exp=%0d", StallCount, exp_cnt); end
        n_cmp++; if (ExWriteReg !== 5'd0) begin n_err++; $display("FAIL lu_bubble got=%0d exp=0", ExWriteReg); end
        tick();
        n_cmp++; if (ExWriteReg !== 5'd9) begin n_err++; $display("FAIL lu_add_ex got=%0d exp=9", ExWriteReg); end
        nops();
    endtask

    task automatic test_rt_unused();
        drv(29, 8, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0);
        tick();
        drv(2, 8, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        n_cmp++; if (StallID !== 1'b0) begin n_err++; $display("FAIL rt_unused_stall got=%b exp=0", StallID); end
        drv(2, 8, 9, 1, 2'b01, 1, 0, 0, 0, 0, 0);
        n_cmp++; if (StallID !== 1'b1) begin n_err++; $display("FAIL rt_used_stall got=%b exp=1", StallID); end
        tick();
        exp_cnt++;
        nops();
    endtask

    task automatic test_branch_load();
        drv(29, 4, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0);
        tick();
        drv(4, 5, 0, 1, 2'b00, 0, 0, 1, 1, 0, 0);
        n_cmp++; if (StallID !== 1'b1) begin n_err++; $display("FAIL bl_stall1 got=%b exp=1", StallID); end
        n_cmp++; if (FlushIF !== 1'b0) begin n_err++; $display("FAIL bl_flush1 got=%b exp=0", FlushIF); end
        tick();
        n_cmp++; if (StallID !== 1'b1) begin n_err++; $display("FAIL bl_stall2 got=%b exp=1", StallID); end
        n_cmp++; if (FlushIF !== 1'b0) begin n_err++; $display("FAIL bl_flush2 got=%b exp=0", FlushIF); end
        tick();
        exp_cnt += 2;
        n_cmp++; if (StallID !== 1'b0) begin n_err++; $display("FAIL bl_resolve got=%b exp=0", StallID); end
        n_cmp++; if (FlushIF !== 1'b1) begin n_err++; $display("FAIL bl_flush got=%b exp=1", FlushIF); end
        n_cmp++; if (StallCount !== 16'(exp_cnt)) begin n_err++; $display("FAIL bl_cnt got=%0d exp=%0d", StallCount, exp_cnt); end
        nops();
    endtask

    task automatic test_branch_alu();
        drv(0, 3, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        tick();
        drv(3, 0, 0, 1, 2'b00, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (StallID !== 1'b1) begin n_err++; $display("FAIL ba_stall got=%b exp=1", StallID); end
        tick();
        exp_cnt++;
        n_cmp++; if (StallID !== 1'b0) begin n_err++; $display("FAIL ba_release got=%b exp=0", StallID); end
        n_cmp++; if (FlushIF !== 1'b0) begin n_err++; $display("FAIL ba_flush got=%b exp=0", FlushIF); end
        n_cmp++; if (StallCount !== 16'(exp_cnt)) begin n_err++; $display("FAIL ba_cnt got=%0d exp=%0d", StallCount, exp_cnt); end
        nops();
    endtask

    task automatic test_reg_zero_link();
        drv(29, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0);
        tick();
        n_cmp++; if (ExWriteReg !== 5'd0) begin n_err++; $display("FAIL z_exwr got=%0d exp=0", ExWriteReg); end
        drv(0, 0, 1, 1, 2'b01, 1, 0, 0, 0, 0, 0);
        n_cmp++; if (StallID !== 1'b0) begin n_err++; $display("FAIL z_stall got=%b exp=0", StallID); end
        nops();
        drv(0, 0, 0, 0, 2'b10, 1, 0, 0, 0, 1, 0);
        n_cmp++; if (FlushIF !== 1'b1) begin n_err++; $display("FAIL jal_flush got=%b exp=1", FlushIF); end
        tick();
        n_cmp++; if (ExWriteReg !== 5'd31) begin n_err++; $display("FAIL jal_exwr got=%0d exp=31", ExWriteReg); end
        drv(31, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);
        n_cmp++; if (StallID !== 1'b1) begin n_err++; $display("FAIL jr_stall got=%b exp=1", StallID); end
        n_cmp++; if (FlushIF !== 1'b0) begin n_err++; $display("FAIL jr_flush_stall got=%b exp=0", FlushIF); end
        tick();
        exp_cnt++;
        n_cmp++; if (StallID !== 1'b0) begin n_err++; $display("FAIL jr_release got=%b exp=0", StallID); end
        n_cmp++; if (FlushIF !== 1'b1) begin n_err++; $display("FAIL jr_flush got=%b exp=1", FlushIF); end
        nops();
    endtask

    task automatic test_reset_mid_stall();
        drv(29, 4, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0);
        tick();
        drv(4, 5, 0, 1, 2'b00, 0, 0, 1, 1, 0, 0);
        tick();
        n_cmp++; if (StallID !== 1'b1) begin n_err++; $display("FAIL mr_stall2 got=%b exp=1", StallID); end
        reset = 1'b1;
        #1;
        exp_cnt = 0;
        n_cmp++; if (StallID !== 1'b0) begin n_err++; $display("FAIL mr_stall got=%b exp=0", StallID); end
        n_cmp++; if (StallCount !== 16'd0) begin n_err++; $display("FAIL mr_cnt got=%0d exp=0", StallCount); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (StallID !== 1'b0) begin n_err++; $display("FAIL mr_post_stall got=%b exp=0", StallID); end
        n_cmp++; if (FlushIF !== 1'b1) begin n_err++; $display("FAIL mr_post_flush got=%b exp=1", FlushIF); end
        n_cmp++; if (ExWriteReg !== 5'd0) begin n_err++; $display("FAIL mr_post_exwr got=%0d exp=0", ExWriteReg); end
        nops();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drv(29, 8, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0);
            tick();
            drv(8, 10, 9, 1, 2'b01, 1, 0, 0, 0, 0, 0);
            tick();
            exp_cnt++;
            tick();
            if (i == 14) begin
                n_cmp++; if (StallCount4 !== 4'd15) begin n_err++; $display("FAIL sat_reach got=%0d exp=15", StallCount4); end
            end
        end
        n_cmp++; if (StallCount4 !== 4'd15) begin n_err++; $display("FAIL sat_hold got=%0d exp=15", StallCount4); end
        n_cmp++; if (StallCount !== 16'(exp_cnt)) begin n_err++; $display("FAIL sat_wide got=%0d exp=%0d", StallCount, exp_cnt); end
        nops();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rt_unused();
        test_branch_load();
        test_branch_alu();
        test_reg_zero_link();
        test_reset_mid_stall();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
